// File: rtl/de2_70_ethernet_st_width_adapter_32to8_if.sv
// Avalon-ST signal bundle for the 32-to-8 width adapter: wide word in, byte symbols out.
// slave is the adapter's view; master is the view of the logic surrounding it.
interface de2_70_ethernet_st_width_adapter_32to8_if #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int IN_SYMBOLS   = 4,
  parameter int EMPTY_WIDTH  = 2
);
  localparam int DATA_WIDTH = SYMBOL_WIDTH * IN_SYMBOLS;

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_sop;
  logic                    in_eop;
  logic [EMPTY_WIDTH-1:0]  in_empty;
  logic                    in_error;

  logic                    out_valid;
  logic                    out_ready;
  logic [SYMBOL_WIDTH-1:0] out_data;
  logic                    out_sop;
  logic                    out_eop;
  logic                    out_error;

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_empty, in_error, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_error
  );

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_empty, in_error, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_error
  );
endinterface

// File: rtl/de2_70_ethernet_st_width_adapter_32to8.sv
// Serialises a held 32-bit Avalon-ST word into MSB-first bytes; first byte 1 cycle after accept.
// in_ready is combinational from out_ready so the next word loads as the last byte leaves.
module de2_70_ethernet_st_width_adapter_32to8 #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int IN_SYMBOLS   = 4,
  parameter int EMPTY_WIDTH  = 2
) (
  input logic clk,
  input logic reset_n,
  de2_70_ethernet_st_width_adapter_32to8_if.slave st
);
  localparam int DATA_WIDTH = SYMBOL_WIDTH * IN_SYMBOLS;
  localparam logic [EMPTY_WIDTH-1:0] MAX_IDX = EMPTY_WIDTH'(IN_SYMBOLS - 1);

  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    sop_q, sop_d;
  logic                    eop_q, eop_d;
  logic [EMPTY_WIDTH-1:0]  empty_q, empty_d;
  logic                    err_q, err_d;
  logic                    hold_vld_q, hold_vld_d;
  logic [EMPTY_WIDTH-1:0]  idx_q, idx_d;

  logic [EMPTY_WIDTH-1:0]  last_idx;
  logic                    at_last;
  logic                    in_rdy;
  logic                    load;
  logic [SYMBOL_WIDTH-1:0] sym_dat;

  // Trailing empty symbols only shorten the word that closes the packet.
  assign last_idx = eop_q ? (MAX_IDX - empty_q) : MAX_IDX;
  assign at_last  = (idx_q == last_idx);
  assign in_rdy   = !hold_vld_q || (st.out_ready && at_last);
  assign load     = st.in_valid && in_rdy;

  always_comb begin
    sym_dat = '0;
    for (int i = 0; i < IN_SYMBOLS; i++) begin
      if (idx_q == EMPTY_WIDTH'(i)) begin
        sym_dat = data_q[(IN_SYMBOLS-1-i)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

  always_comb begin
    data_d     = data_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    empty_d    = empty_q;
    err_d      = err_q;
    hold_vld_d = hold_vld_q;
    idx_d      = idx_q;
    // A load on the last-symbol cycle overrides the drain so there is no bubble.
    if (load) begin
      data_d     = st.in_data;
      sop_d      = st.in_sop;
      eop_d      = st.in_eop;
      empty_d    = st.in_empty;
      err_d      = st.in_error;
      hold_vld_d = 1'b1;
      idx_d      = '0;
    end else if (hold_vld_q && st.out_ready) begin
      if (at_last) begin
        hold_vld_d = 1'b0;
        idx_d      = '0;
      end else begin
        idx_d = idx_q + EMPTY_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      empty_q    <= '0;
      err_q      <= 1'b0;
      hold_vld_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
      hold_vld_q <= hold_vld_d;
      idx_q      <= idx_d;
    end
  end

  assign st.in_ready  = in_rdy;
  assign st.out_valid = hold_vld_q;
  assign st.out_data  = sym_dat;
  assign st.out_sop   = sop_q && (idx_q == '0);
  assign st.out_eop   = eop_q && at_last;
  assign st.out_error = err_q && eop_q && at_last;
endmodule

// File: tb/tb_de2_70_ethernet_st_width_adapter_32to8.sv
// Directed bench for the 32-to-8 adapter: inputs change on negedge, outputs sampled 1ns later.
module tb_de2_70_ethernet_st_width_adapter_32to8;
  logic clk;
  logic reset_n;
  int   errs;
  int   checks;

  de2_70_ethernet_st_width_adapter_32to8_if st ();

  de2_70_ethernet_st_width_adapter_32to8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .st      (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put_word(input logic [31:0] d, input logic s, input logic e,
                          input logic [1:0] emp, input logic er);
    st.in_valid = 1'b1;
    st.in_data  = d;
    st.in_sop   = s;
    st.in_eop   = e;
    st.in_empty = emp;
    st.in_error = er;
  endtask

  // Checks one output symbol plus in_ready, then advances to the next negedge.
  task automatic sym(input string tag, input logic [7:0] d, input logic s, input logic e,
                     input logic er, input logic ir);
    #1;
    chk({tag, ".vld"}, 32'(st.out_valid), 32'd1);
    chk({tag, ".dat"}, 32'(st.out_data), 32'(d));
    chk({tag, ".sop"}, 32'(st.out_sop), 32'(s));
    chk({tag, ".eop"}, 32'(st.out_eop), 32'(e));
    chk({tag, ".err"}, 32'(st.out_error), 32'(er));
    chk({tag, ".ird"}, 32'(st.in_ready), 32'(ir));
    tick();
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, ".vld"}, 32'(st.out_valid), 32'd0);
    chk({tag, ".ird"}, 32'(st.in_ready), 32'd1);
  endtask

  initial begin
    errs         = 0;
    checks       = 0;
    reset_n      = 1'b0;
    st.out_ready = 1'b1;
    put_word(32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    st.in_valid  = 1'b0;
    tick();
    tick();
    #1;
    chk("rst.vld", 32'(st.out_valid), 32'd0);
    chk("rst.dat", 32'(st.out_data), 32'd0);
    chk("rst.sop", 32'(st.out_sop), 32'd0);
    chk("rst.eop", 32'(st.out_eop), 32'd0);
    chk("rst.err", 32'(st.out_error), 32'd0);
    chk("rst.ird", 32'(st.in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();

    // Single word packet, full throughput downstream.
    put_word(32'hAABBCCDD, 1'b1, 1'b1, 2'd0, 1'b0);
    idle_chk("t1.pre");
    tick();
    st.in_valid = 1'b0;
    sym("t1.s0", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    sym("t1.s1", 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t1.s2", 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t1.s3", 8'hDD, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_chk("t1.end");

    // Back-to-back words, second one loads as 04 leaves.
    put_word(32'h01020304, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    put_word(32'h05060708, 1'b0, 1'b1, 2'd2, 1'b0);
    sym("t2.s0", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    sym("t2.s1", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t2.s2", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t2.s3", 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    st.in_valid = 1'b0;
    sym("t2.s4", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t2.s5", 8'h06, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_chk("t2.end");

    // One-symbol errored packet, followed immediately by a clean packet.
    put_word(32'h11223344, 1'b1, 1'b1, 2'd3, 1'b1);
    tick();
    put_word(32'h55667788, 1'b1, 1'b1, 2'd0, 1'b0);
    sym("t3.s0", 8'h11, 1'b1, 1'b1, 1'b1, 1'b1);
    st.in_valid = 1'b0;
    sym("t3.s1", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    sym("t3.s2", 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t3.s3", 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t3.s4", 8'h88, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_chk("t3.end");

    // Downstream stalls on the second symbol for two cycles.
    put_word(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0, 1'b0);
    tick();
    st.in_valid = 1'b0;
    sym("t4.s0", 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
    st.out_ready = 1'b0;
    sym("t4.st0", 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t4.st1", 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    st.out_ready = 1'b1;
    sym("t4.s1", 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t4.s2", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t4.s3", 8'hD4, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_chk("t4.end");

    // Empty is ignored on a non-eop word.
    put_word(32'hDEADBEEF, 1'b1, 1'b0, 2'd2, 1'b0);
    tick();
    st.in_valid = 1'b0;
    sym("t5.s0", 8'hDE, 1'b1, 1'b0, 1'b0, 1'b0);
    sym("t5.s1", 8'hAD, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t5.s2", 8'hBE, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t5.s3", 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_chk("t5.end");

    // Asynchronous reset in the middle of a word.
    put_word(32'hCAFEF00D, 1'b1, 1'b1, 2'd0, 1'b0);
    tick();
    st.in_valid = 1'b0;
    sym("t6.s0", 8'hCA, 1'b1, 1'b0, 1'b0, 1'b0);
    sym("t6.s1", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t6.pre.vld", 32'(st.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6.rst.vld", 32'(st.out_valid), 32'd0);
    chk("t6.rst.sop", 32'(st.out_sop), 32'd0);
    chk("t6.rst.eop", 32'(st.out_eop), 32'd0);
    chk("t6.rst.dat", 32'(st.out_data), 32'd0);
    chk("t6.rst.ird", 32'(st.in_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    idle_chk("t6.rel");
    put_word(32'h00000000, 1'b1, 1'b1, 2'd0, 1'b0);
    tick();
    st.in_valid = 1'b0;
    sym("t6.s2", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    sym("t6.s3", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t6.s4", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sym("t6.s5", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_chk("t6.end");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
